// File: rtl/cache_pkg.sv
// Shared constants, index extraction and FSM state encoding for the cache miss controller.
`timescale 1ns/1ps
package cache_pkg;
  localparam int NUM_SETS  = 32;
  localparam int NUM_WAYS  = 4;
  localparam int INDEX_W   = 5;
  localparam int INDEX_LSB = 2;
  localparam int INDEX_MSB = INDEX_LSB + INDEX_W - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CWRITE,
    S_MEM_WR,
    S_MEM_RD,
    S_FILL,
    S_RESP
  } state_t;

  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
    return addr[INDEX_MSB:INDEX_LSB];
  endfunction
endpackage

// File: rtl/cache_victim_sel.sv
// Per-set FIFO victim pointers: read by index, advance on a strobe, cleared by reset.
`timescale 1ns/1ps
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int NUM_SETS = cache_pkg::NUM_SETS,
  parameter int NUM_WAYS = cache_pkg::NUM_WAYS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_SETS)-1:0] i_index,
  input  logic                        i_inc,
  output logic [$clog2(NUM_WAYS)-1:0] o_way
);
  logic [$clog2(NUM_WAYS)-1:0] r_ptr [NUM_SETS];

  // Pointer width equals log2(ways), so the increment wraps 3 -> 0 on its own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SETS; i++) r_ptr[i] <= '0;
    end else if (i_inc) begin
      r_ptr[i_index] <= r_ptr[i_index] + 1'b1;
    end
  end

  assign o_way = r_ptr[i_index];
endmodule

// File: rtl/cache_miss_controller.sv
// Write-through, write-allocate miss controller for a 4-way cache with a backing memory.
// Optional hit/miss counters are enabled by defining CACHE_MISS_CONTROLLER_STATS_EN.
//
// state    | meaning
// IDLE     | waiting for cpu_req
// LOOKUP   | cache probed with latched address
// CWRITE   | write data into cache (allocates victim way on miss)
// MEM_WR   | write-through to memory, wait for ack
// MEM_RD   | read miss fetch from memory, wait for ack
// FILL     | fetched word written into victim way
// RESP     | one-cycle cpu_ready pulse
`timescale 1ns/1ps
module cache_miss_controller
  import cache_pkg::*;
#(
  parameter int NUM_SETS = cache_pkg::NUM_SETS,
  parameter int NUM_WAYS = cache_pkg::NUM_WAYS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic        o_cpu_ready,
  output logic [31:0] o_cpu_rdata,
  output logic        o_busy,
  output logic        o_c_read,
  output logic        o_c_write,
  output logic [31:0] o_c_addr,
  output logic [31:0] o_c_wdata,
  output logic [1:0]  o_c_replace_way,
  input  logic        i_c_hit,
  input  logic [31:0] i_c_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
`ifdef CACHE_MISS_CONTROLLER_STATS_EN
  output logic [15:0] o_hit_cnt,
  output logic [15:0] o_miss_cnt,
`endif
  input  logic [31:0] i_mem_rdata
);
  state_t      r_state;
  logic        r_we;
  logic        r_hit;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_cpu_ready;
  logic        r_c_read;
  logic        r_c_write;
  logic        r_mem_req;
  logic        w_inc;
  logic [1:0]  w_victim;

  // Victim advances on every fill and on a write that missed (allocation).
  assign w_inc = ((r_state == S_CWRITE) && !r_hit) || (r_state == S_FILL);

  cache_victim_sel #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) u_victim (
    .clk     (clk),
    .reset   (reset),
    .i_index (addr_index(r_addr)),
    .i_inc   (w_inc),
    .o_way   (w_victim)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_hit       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_cpu_ready <= 1'b0;
      r_c_read    <= 1'b0;
      r_c_write   <= 1'b0;
      r_mem_req   <= 1'b0;
    end else begin
      r_cpu_ready <= 1'b0;
      r_c_read    <= 1'b0;
      r_c_write   <= 1'b0;
      case (r_state)
        S_IDLE: if (i_cpu_req) begin
          r_we     <= i_cpu_we;
          r_addr   <= i_cpu_addr;
          r_wdata  <= i_cpu_wdata;
          r_rdata  <= '0;
          r_c_read <= 1'b1;
          r_state  <= S_LOOKUP;
        end
        S_LOOKUP: begin
          r_hit <= i_c_hit;
          if (r_we) begin
            r_c_write <= 1'b1;
            r_state   <= S_CWRITE;
          end else if (i_c_hit) begin
            r_rdata     <= i_c_rdata;
            r_cpu_ready <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_mem_req <= 1'b1;
            r_state   <= S_MEM_RD;
          end
        end
        S_CWRITE: begin
          r_mem_req <= 1'b1;
          r_state   <= S_MEM_WR;
        end
        S_MEM_WR: if (i_mem_ack) begin
          r_mem_req   <= 1'b0;
          r_cpu_ready <= 1'b1;
          r_state     <= S_RESP;
        end
        S_MEM_RD: if (i_mem_ack) begin
          r_mem_req <= 1'b0;
          r_rdata   <= i_mem_rdata;
          r_c_write <= 1'b1;
          r_state   <= S_FILL;
        end
        S_FILL: begin
          r_cpu_ready <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy          = (r_state != S_IDLE);
  assign o_cpu_ready     = r_cpu_ready;
  assign o_cpu_rdata     = r_cpu_ready ? r_rdata : '0;
  assign o_c_read        = r_c_read;
  assign o_c_write       = r_c_write;
  assign o_c_addr        = r_addr;
  assign o_c_wdata       = (r_state == S_FILL) ? r_rdata : r_wdata;
  assign o_c_replace_way = r_c_write ? w_victim : 2'd0;
  assign o_mem_req       = r_mem_req;
  assign o_mem_we        = r_we;
  assign o_mem_addr      = r_addr;
  assign o_mem_wdata     = r_wdata;

`ifdef CACHE_MISS_CONTROLLER_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (i_c_hit && (r_hit_cnt != 16'hFFFF))         r_hit_cnt  <= r_hit_cnt + 1'b1;
      else if (!i_c_hit && (r_miss_cnt != 16'hFFFF))  r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
`endif
endmodule

// File: tb/tb_cache_miss_controller.sv
// Directed bench for cache_miss_controller with a behavioural 4-way cache and a delayed-ack memory.
`timescale 1ns/1ps
module tb_cache_miss_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ready, busy, c_read, c_write, c_hit, mem_req, mem_we;
  logic [31:0] cpu_rdata, c_addr, c_wdata, c_rdata, mem_addr, mem_wdata;
  logic [1:0]  c_replace_way;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef CACHE_MISS_CONTROLLER_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  cache_miss_controller dut (
    .clk(clk), .reset(reset),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ready(cpu_ready), .o_cpu_rdata(cpu_rdata), .o_busy(busy),
    .o_c_read(c_read), .o_c_write(c_write), .o_c_addr(c_addr), .o_c_wdata(c_wdata),
    .o_c_replace_way(c_replace_way), .i_c_hit(c_hit), .i_c_rdata(c_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack),
`ifdef CACHE_MISS_CONTROLLER_STATS_EN
    .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt),
`endif
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Cache model: 32 sets x 4 ways; write hits update in place, otherwise the victim way.
  logic        cv  [32][4];
  logic [24:0] ctg [32][4];
  logic [31:0] cdt [32][4];

  always_comb begin
    c_hit   = 1'b0;
    c_rdata = '0;
    for (int w = 0; w < 4; w++)
      if (cv[c_addr[6:2]][w] && ctg[c_addr[6:2]][w] == c_addr[31:7]) begin
        c_hit   = 1'b1;
        c_rdata = cdt[c_addr[6:2]][w];
      end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 32; s++)
        for (int w = 0; w < 4; w++) cv[s][w] <= 1'b0;
    end else if (c_write) begin
      int way;
      way = int'(c_replace_way);
      for (int w = 0; w < 4; w++)
        if (cv[c_addr[6:2]][w] && ctg[c_addr[6:2]][w] == c_addr[31:7]) way = w;
      cv[c_addr[6:2]][way]  <= 1'b1;
      ctg[c_addr[6:2]][way] <= c_addr[31:7];
      cdt[c_addr[6:2]][way] <= c_wdata;
    end
  end

  // Memory model: ack in the ack_delay-th cycle of a request; unwritten words return a pattern.
  logic [31:0] mem_arr [logic [31:0]];
  int          ack_delay = 1;
  int          ack_cnt   = 0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mem_req && !mem_ack) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_val(mem_addr);
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        ack_cnt   = 0;
      end
    end else begin
      mem_ack = 1'b0;
    end
  end

  // Results of the most recent access.
  logic [31:0] t_rd, t_maddr, t_mwd, t_cwd;
  logic        t_mwe;
  logic [1:0]  t_way;
  int          t_lat, t_ack, t_nmem, t_nwr, t_both = 0;

  // Latencies count rising edges, the accept edge being edge 1.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int dly, input bit pulse);
    ack_delay = dly;
    t_rd = '0; t_maddr = '0; t_mwd = '0; t_cwd = '0; t_mwe = 1'b0; t_way = '0;
    t_lat = 0; t_ack = 0; t_nmem = 0; t_nwr = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk);
      if (mem_ack) t_ack = cyc;
      #1;
      if (cyc == 1) cpu_req = 1'b0;
      if (pulse && cyc == 3) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0200;
      end
      if (pulse && cyc == 4) cpu_req = 1'b0;
      if (c_read && c_write) t_both++;
      if (mem_req) begin
        if (t_nmem == 0) begin
          t_mwe = mem_we; t_maddr = mem_addr; t_mwd = mem_wdata;
        end
        t_nmem++;
      end
      if (c_write) begin
        t_way = c_replace_way; t_cwd = c_wdata; t_nwr++;
      end
      if (cpu_ready) begin
        t_rd  = cpu_rdata;
        t_lat = cyc;
        break;
      end
    end
    chk("ready_seen", 32'(cpu_ready), 32'd1);
    @(posedge clk); #1;
    chk("ready_one_cycle", 32'(cpu_ready), 32'd0);
    chk("idle_after_resp", 32'(busy), 32'd0);
  endtask

  logic [31:0] miss_addrs [5] = '{32'h000, 32'h080, 32'h100, 32'h180, 32'h200};
  logic [1:0]  miss_ways  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    mem_arr[32'h0000_0040] = 32'hDEAD_BEEF;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_c_addr", c_addr, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Read miss of 0x40, ack after 3 cycles; a busy-time cpu_req pulse must be ignored.
    access(1'b0, 32'h0000_0040, 32'd0, 3, 1'b1);
    chk("rd40_mem_we", 32'(t_mwe), 32'd0);
    chk("rd40_mem_addr", t_maddr, 32'h40);
    chk("rd40_fill_way", 32'(t_way), 32'd0);
    chk("rd40_fill_data", t_cwd, 32'hDEAD_BEEF);
    chk("rd40_rdata", t_rd, 32'hDEAD_BEEF);
    chk("rd40_ack_latency", 32'(t_lat - t_ack + 1), 32'd2);
    chk("rd40_ack_wait", 32'(t_nmem), 32'd3);

    // Re-read hits.
    access(1'b0, 32'h0000_0040, 32'd0, 1, 1'b0);
    chk("hit40_latency", 32'(t_lat), 32'd2);
    chk("hit40_rdata", t_rd, 32'hDEAD_BEEF);
    chk("hit40_no_mem", 32'(t_nmem), 32'd0);
    chk("hit40_no_cwrite", 32'(t_nwr), 32'd0);
`ifdef CACHE_MISS_CONTROLLER_STATS_EN
    chk("stats_hit", 32'(hit_cnt), 32'd1);
    chk("stats_miss", 32'(miss_cnt), 32'd1);
`endif

    // Five read misses in set 0 walk the victim pointer round and wrap.
    for (int i = 0; i < 5; i++) begin
      access(1'b0, miss_addrs[i], 32'd0, 1 + i, 1'b0);
      chk($sformatf("set0_way_%0d", i), 32'(t_way), 32'(miss_ways[i]));
      chk($sformatf("set0_rdata_%0d", i), t_rd, miss_addrs[i] ^ 32'hA5A5_0000);
    end

    // Reset while waiting in MEM_RD.
    ack_delay = 20;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0300;
    @(posedge clk); #1; cpu_req = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_reached_mem_rd", 32'(mem_req), 32'd1);
    @(negedge clk); reset = 1'b1; #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    chk("rst_mid_strobes", {30'd0, c_read, c_write}, 32'd0);
    chk("rst_mid_ready", 32'(cpu_ready), 32'd0);
    @(negedge clk); reset = 1'b0;
    access(1'b0, 32'h0000_0300, 32'd0, 1, 1'b0);
    chk("reissue_addr", t_maddr, 32'h300);
    chk("reissue_way", 32'(t_way), 32'd0);
    chk("reissue_rdata", t_rd, 32'hA5A5_0300);
    chk("reissue_ack_latency", 32'(t_lat - t_ack + 1), 32'd2);

    // Write miss of 0x80 allocates way 1, then writes through.
    access(1'b1, 32'h0000_0080, 32'h1234_5678, 2, 1'b0);
    chk("wr80_cwrite_cnt", 32'(t_nwr), 32'd1);
    chk("wr80_way", 32'(t_way), 32'd1);
    chk("wr80_cdata", t_cwd, 32'h1234_5678);
    chk("wr80_mem_we", 32'(t_mwe), 32'd1);
    chk("wr80_mem_addr", t_maddr, 32'h80);
    chk("wr80_mem_wdata", t_mwd, 32'h1234_5678);
    chk("wr80_rdata_zero", t_rd, 32'd0);

    access(1'b0, 32'h0000_0080, 32'd0, 1, 1'b0);
    chk("rd80_hit_rdata", t_rd, 32'h1234_5678);
    chk("rd80_no_mem", 32'(t_nmem), 32'd0);

    // Next miss in set 0 must use way 2: the hit did not advance the pointer.
    access(1'b0, 32'h0000_0100, 32'd0, 2, 1'b1);
    chk("rd100_way", 32'(t_way), 32'd2);
    chk("rd100_rdata", t_rd, 32'hA5A5_0100);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("busy_req_ignored", 32'(busy), 32'd0);
    end

    chk("no_read_write_overlap", 32'(t_both), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
